vga_timing_gen: RTL



---
 rtl/vga_timing_gen_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and the sync bundle carried by the delay line.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package defs_vga;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    typedef struct packed {
        logic draw_active;
        logic h_sync;
        logic v_sync;
    } vga_sync_t;

    // Counter width for a range of v values, never narrower than one bit.
    function automatic int pix_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel strobe in, raster position and sync decode out.
interface vga_timing_gen_if #(
    parameter int X_W  = defs_vga::pix_w(defs_vga::VGA_H_ACTIVE),
    parameter int Y_W  = defs_vga::pix_w(defs_vga::VGA_V_ACTIVE),
    parameter int FC_W = 8
);
    logic            i_pix_en;
    logic            o_draw_active;
    logic [X_W-1:0]  o_active_x;
    logic [Y_W-1:0]  o_active_y;
    logic            o_h_sync;
    logic            o_v_sync;
    logic            o_line_start;
    logic            o_frame_start;
    logic [FC_W-1:0] o_frame_cnt;
    logic            o_draw_active_d;
    logic            o_h_sync_d;
    logic            o_v_sync_d;

    modport master (
        input  i_pix_en,
        output o_draw_active, o_active_x, o_active_y,
        output o_h_sync, o_v_sync, o_line_start, o_frame_start,
        output o_frame_cnt, o_draw_active_d, o_h_sync_d, o_v_sync_d
    );

    modport slave (
        output i_pix_en,
        input  o_draw_active, o_active_x, o_active_y,
        input  o_h_sync, o_v_sync, o_line_start, o_frame_start,
        input  o_frame_cnt, o_draw_active_d, o_h_sync_d, o_v_sync_d
    );
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register over the sync bundle; depth 0 is a wire.
module vga_delay_line
    import defs_vga::*;
#(
    parameter int        DEPTH   = 0,
    parameter vga_sync_t RST_VAL = '0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  vga_sync_t din,
    output vga_sync_t dout
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_sr
        vga_sync_t stage [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster counter with sync/active decode and an
// aligned, strobe-gated delay line for the framebuffer pipeline.
module vga_timing_gen
    import defs_vga::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int SYNC_POL    = 0,
    parameter int PIPE_DLY    = 0,
    parameter int FRAME_CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int XC_W     = pix_w(H_TOTAL);
    localparam int YC_W     = pix_w(V_TOTAL);
    localparam int AX_W     = pix_w(H_ACTIVE);
    localparam int AY_W     = pix_w(V_ACTIVE);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    localparam vga_sync_t SYNC_IDLE = '{
        draw_active: 1'b0,
        h_sync:      ~SYNC_ON,
        v_sync:      ~SYNC_ON
    };

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        PIPE_DLY < 0 || PIPE_DLY > 8 || FRAME_CNT_W < 1) begin : g_bad_param
        $error("vga_timing_gen: illegal timing/PIPE_DLY/FRAME_CNT_W");
    end

    logic [XC_W-1:0]        x;
    logic [YC_W-1:0]        y;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   x_wrap;
    logic                   y_wrap;
    logic                   draw_active;
    logic                   hs_on;
    logic                   vs_on;
    vga_sync_t              cur;
    vga_sync_t              dly;

    assign x_wrap = (x == XC_W'(H_TOTAL - 1));
    assign y_wrap = (y == YC_W'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else if (vga.i_pix_en) begin
            x <= x_wrap ? '0 : x + 1'b1;
            if (x_wrap) begin
                y <= y_wrap ? '0 : y + 1'b1;
                if (y_wrap) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign draw_active = (x < XC_W'(H_ACTIVE)) && (y < YC_W'(V_ACTIVE));
    assign hs_on = (x >= XC_W'(HS_START)) && (x < XC_W'(HS_END));
    assign vs_on = (y >= YC_W'(VS_START)) && (y < YC_W'(VS_END));

    assign cur = '{
        draw_active: draw_active,
        h_sync:      hs_on ? SYNC_ON : ~SYNC_ON,
        v_sync:      vs_on ? SYNC_ON : ~SYNC_ON
    };

    vga_delay_line #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (vga.i_pix_en),
        .din  (cur),
        .dout (dly)
    );

    assign vga.o_draw_active   = cur.draw_active;
    assign vga.o_active_x      = draw_active ? AX_W'(x) : '0;
    assign vga.o_active_y      = draw_active ? AY_W'(y) : '0;
    assign vga.o_h_sync        = cur.h_sync;
    assign vga.o_v_sync        = cur.v_sync;
    assign vga.o_line_start    = (x == '0);
    assign vga.o_frame_start   = (x == '0) && (y == '0);
    assign vga.o_frame_cnt     = frame_cnt;
    assign vga.o_draw_active_d = dly.draw_active;
    assign vga.o_h_sync_d      = dly.h_sync;
    assign vga.o_v_sync_d      = dly.v_sync;
endmodule
